uart_rx_sequencer: RTL
======================

// Module: uart_rx_sequencer
// PURPOSE
//  Rx frame controller: sequences the UART receive datapath after start-bit detection.
//  Times each bit from start_detected, samples serial_in_synced at mid-bit, and shifts in data LSB first.
//  Checks parity and stop bit, then presents the byte on a one-deep valid/ready holding register.
//  Exports the Rx state code that the start-bit detector and its formal checks consume.
// PARAMETERS
//  INPUT_DATA_WIDTH  8     data bits per frame (state encoding below scales with it)
//  PARITY_ENABLED    1     1: parity bit present between data and stop; 0: no parity bit, never sampled
//  PARITY_ODD        0     0: even parity, 1: odd parity
//  CLOCKS_PER_BIT    5000  clk cycles per UART bit (must be >= 4; simulation uses 8)
// PORTS
//  clk                input   1     system clock, all state on rising edge
//  reset_n            input   1     asynchronous, active-low reset
//  serial_in_synced   input   1     Rx line, already synchronised to clk
//  start_detected     input   1     from start-bit detector; held high during a frame
//  rx_ready           input   1     consumer accepts rx_data when rx_valid & rx_ready
//  clear_overrun      input   1     single-cycle pulse, clears overrun
//  state              output  S     current Rx state, S = $clog2(INPUT_DATA_WIDTH+4)
//  busy               output  1     state != IDLE
//  rx_data            output  W     received byte, W = INPUT_DATA_WIDTH
//  rx_valid           output  1     holding register full
//  parity_error       output  1     parity mismatch for frame in rx_data; 0 when PARITY_ENABLED=0
//  framing_error      output  1     stop bit sampled 0 for frame in rx_data
//  overrun            output  1     sticky: a completed frame was dropped
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, bit counter=0, shift reg=0, all outputs 0; aborts any frame mid-flight.
//  State codes: IDLE=0, START=1, DATA_k=2+k (k=0..W-1), PARITY=W+2, STOP=W+3 (W=8: PARITY=10, STOP=11).
//  Edge: start_detected registered; rising edge (now 1, prev 0) in IDLE -> START next cycle, bit_cnt=0.
//    start_detected held high, or rising edge outside IDLE: ignored.
//  bit_cnt counts 0..CLOCKS_PER_BIT-1 in every non-IDLE state; wraps to 0 on state advance.
//  Sample point: bit_cnt == CLOCKS_PER_BIT/2 (integer division).
//  START: sample 1 -> false start, IDLE next cycle, no frame output.
//    sample 0 -> stay; at bit_cnt==CLOCKS_PER_BIT-1 -> DATA_0.
//  DATA_k: sample shifts into bit k (LSB first); at end of bit -> DATA_k+1.
//    DATA_{W-1} -> PARITY if PARITY_ENABLED, else STOP.
//  PARITY: perr = XOR(data bits, sampled bit, PARITY_ODD); at end of bit -> STOP.
//  STOP: at sample point, frame completes; IDLE next cycle (half-bit early, ready for next start edge).
//  Completion cycle (C), holding register:
//    rx_valid=0, or rx_valid=1 & rx_ready=1: load rx_data, parity_error, framing_error=~sample; rx_valid=1 at C+1.
//    rx_valid=1 & rx_ready=0: frame dropped, rx_data and flags unchanged, overrun=1 at C+1.
//  Handshake: rx_valid & rx_ready without completion -> rx_valid=0 next cycle; rx_data held.
//  overrun: set overrides clear_overrun in the same cycle; else cleared by clear_overrun.
//  Errors never suppress rx_valid; the frame is delivered with its flags set.
//  serial_in_synced is sampled only at the sample point; transitions between sample points have no effect.
//  Counter width $clog2(CLOCKS_PER_BIT); no arithmetic overflow possible.
// TESTING (CLOCKS_PER_BIT=8, W=8, even parity)
//  Frame 0xA5, parity 0, stop 1 -> rx_valid=1, rx_data=8'hA5, parity_error=0, framing_error=0.
//    state walks 1,2..9,10,11,0.
//  Frame 0x01 with parity 0 -> parity_error=1.
//    Same with PARITY_ODD=1 -> parity_error=0.
//  Frame 0x3C with stop bit 0 -> rx_valid=1, rx_data=8'h3C, framing_error=1.
//  Line low 2 clks after start edge, then high -> state returns 0 after START sample, rx_valid stays 0.
//  Frames 0x11 then 0x22, rx_ready=0 -> rx_data=8'h11, overrun=1.
//    Then rx_ready=1 for 1 cycle -> rx_valid=0; clear_overrun -> overrun=0.
//  reset_n low mid DATA_3 -> state=0, outputs 0 immediately; next 0x5A frame received correctly.
//  rx_ready=1 in completion cycle with rx_valid=1 -> new byte loaded, rx_valid stays 1, overrun=0.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// UART receive frame sequencer: times each bit after start detection, samples at mid-bit,
// checks parity/stop and delivers the byte through a one-deep valid/ready holding register.
module uart_rx_sequencer #(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned PARITY_ENABLED   = 1,
    parameter int unsigned PARITY_ODD       = 0,
    parameter int unsigned CLOCKS_PER_BIT   = 5000
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  serial_in_synced,
    input  logic                                  start_detected,
    input  logic                                  rx_ready,
    input  logic                                  clear_overrun,
    output logic [$clog2(INPUT_DATA_WIDTH+4)-1:0] state,
    output logic                                  busy,
    output logic [INPUT_DATA_WIDTH-1:0]           rx_data,
    output logic                                  rx_valid,
    output logic                                  parity_error,
    output logic                                  framing_error,
    output logic                                  overrun
);

    localparam int unsigned W     = INPUT_DATA_WIDTH;
    localparam int unsigned S_W   = $clog2(W + 4);
    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLOCKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic             ODD_BIT  = 1'(PARITY_ODD);
    localparam logic             PAR_EN   = (PARITY_ENABLED != 0);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_START,
        PH_DATA,
        PH_PARITY,
        PH_STOP
    } phase_e;

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             perr_q, perr_d;
    logic             start_q;
    logic [S_W-1:0]   state_q, state_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic             par_err_q, par_err_d;
    logic             frm_err_q, frm_err_d;
    logic             ovr_q, ovr_d;

    logic sample_pt;
    logic end_bit;
    logic complete;
    logic ovr_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            start_q   <= 1'b0;
            state_q   <= '0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            start_q   <= start_detected;
            state_q   <= state_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

    // Frame sequencing, holding register and exported state code
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        ovr_d     = ovr_q;
        state_d   = '0;
        busy_d    = 1'b0;
        complete  = 1'b0;
        ovr_set   = 1'b0;
        sample_pt = (cnt_q == CNT_MID);
        end_bit   = (cnt_q == CNT_LAST);

        if (phase_q != PH_IDLE) begin
            cnt_d = end_bit ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (phase_q)
            PH_IDLE: begin
                if (start_detected && !start_q) begin
                    phase_d = PH_START;
                    cnt_d   = '0;
                end
            end
            PH_START: begin
                if (sample_pt && serial_in_synced) begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end else if (end_bit) begin
                    phase_d = PH_DATA;
                    idx_d   = '0;
                end
            end
            PH_DATA: begin
                if (sample_pt) begin
                    shift_d = {serial_in_synced, shift_q[W-1:1]};
                end
                if (end_bit) begin
                    if (idx_q == IDX_LAST) begin
                        phase_d = PAR_EN ? PH_PARITY : PH_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PH_PARITY: begin
                if (sample_pt) begin
                    perr_d = (^shift_q) ^ serial_in_synced ^ ODD_BIT;
                end
                if (end_bit) begin
                    phase_d = PH_STOP;
                end
            end
            PH_STOP: begin
                // Return to idle at mid stop bit so the next start edge is not missed
                if (sample_pt) begin
                    phase_d  = PH_IDLE;
                    cnt_d    = '0;
                    complete = 1'b1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d    = shift_q;
                par_err_d = PAR_EN & perr_q;
                frm_err_d = ~serial_in_synced;
                valid_d   = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end

        case (phase_d)
            PH_IDLE:   state_d = '0;
            PH_START:  state_d = S_W'(1);
            PH_DATA:   state_d = S_W'(2) + S_W'(idx_d);
            PH_PARITY: state_d = S_W'(W + 2);
            PH_STOP:   state_d = S_W'(W + 3);
            default:   state_d = '0;
        endcase
        busy_d = (phase_d != PH_IDLE);
    end

    assign state         = state_q;
    assign busy          = busy_q;
    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign parity_error  = par_err_q;
    assign framing_error = frm_err_q;
    assign overrun       = ovr_q;

endmodule
